bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 14: binary operand width; legal range 10..14; one conversion step per bit.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 bin  input  BIN_W  unsigned binary operand, captured on the accepted start edge.
REQ-006 ones, tens, hund, thou  output  4 each  registered BCD digits of the last completed conversion; these drive the display scanner's digit inputs directly.
REQ-007 busy  output  1  high from the accept edge until the result-load edge.
REQ-008 done  output  1  one-cycle pulse marking a fresh result.
REQ-009 ovf  output  1  registered; high when the last converted operand exceeded 9999.

Function
REQ-010 States SHALL be IDLE, CONV and DONE, encoded in a 2-bit register.
REQ-011 IDLE: start=1 at edge E0 SHALL latch bin into a shift register, clear a 20-bit BCD scratch (5 digits) and a step counter, set busy=1 and go to CONV.
REQ-012 CONV: each edge SHALL first add 3 to every scratch digit that is >=5, then left-shift the {scratch, operand} pair by one bit; after BIN_W edges (E1..E_BIN_W) the state SHALL go to DONE.
REQ-013 DONE: at the next edge, outputs SHALL load from the scratch (REQ-016), ovf SHALL update, done SHALL be 1, busy SHALL be 0, and the state SHALL return to IDLE.
REQ-014 done SHALL be high for exactly one cycle; with BIN_W=14 it is set at E15 and cleared at E16.
REQ-015 Latency from the accept edge to done=1 SHALL be BIN_W+1 cycles; the earliest next accept is the edge after done rises (E16 for BIN_W=14).
REQ-016 ones/tens/hund/thou SHALL hold their value during CONV and DONE and change only on the result-load edge, so the downstream scanner never shows a partial value.
REQ-017 start while busy or in DONE SHALL be ignored without queuing; bin changes after E0 SHALL NOT affect the result.
REQ-018 ovf SHALL be 1 iff the ten-thousands scratch digit is nonzero at result load.
REQ-019 All arithmetic SHALL be unsigned; each scratch digit SHALL stay in 0..9 after every step.

Reset
REQ-020 RST_N=0 at an edge SHALL force IDLE and clear the step counter, scratch, ones, tens, hund, thou, busy, done and ovf to 0.
REQ-021 Reset during CONV or DONE SHALL abort the conversion, produce no done pulse, and leave no partial result on the outputs.
REQ-022 start in the same cycle as RST_N=0 SHALL be ignored.

Configuration
REQ-023 Macro BIN2BCD_SAT_EN defined: when ovf is set, the outputs SHALL load 9,9,9,9 (thou..ones).
REQ-024 Macro BIN2BCD_SAT_EN undefined: the outputs SHALL load the low four scratch digits (the result is bin mod 10000) and ovf is still reported.

Verification
REQ-025 bin=1234, start pulse at E0 -> busy for E1..E14, done=1 after E15 only, thou/hund/tens/ones = 1/2/3/4, ovf=0.
REQ-026 bin=0, then bin=9999 back-to-back (second start at E16) -> 0/0/0/0 then 9/9/9/9, two done pulses 16 cycles apart, ovf=0.
REQ-027 bin=12345 -> ovf=1; outputs 9/9/9/9 with BIN2BCD_SAT_EN defined, 2/3/4/5 without it.
REQ-028 bin=5678 converted, then start with bin=42 at E5 of a conversion of bin=100 -> the second start is ignored; outputs go from 5/6/7/8 to 0/1/0/0 at that conversion's load edge, with no intermediate values.
REQ-029 RST_N=0 at E7 of a conversion of bin=4321 -> all outputs 0 at the next cycle, no done pulse, state IDLE; a new start then converts normally.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to 4-digit BCD; done pulses BIN_W+1 cycles after accept, start ignored unless idle.
// Define BIN2BCD_SAT_EN to show 9999 on overflow instead of bin mod 10000.
module bin2bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic [3:0]       ones,
   output logic [3:0]       tens,
   output logic [3:0]       hund,
   output logic [3:0]       thou,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam int CNT_W = $clog2(BIN_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [BIN_W-1:0] opnd;
   logic [19:0]      scratch;
   logic [19:0]      adj;
   logic [CNT_W-1:0] step;
   logic             last_step;
   logic             sat;

   // Digits >= 5 get +3 so the following doubling carries correctly into the next digit.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 5; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   assign last_step = (step == CNT_W'(BIN_W - 1));
   assign sat       = |scratch[19:16];

   always_ff @(posedge CLK) begin
      if (!RST_N)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONV;
         CONV:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         opnd    <= '0;
         scratch <= '0;
         step    <= '0;
         ones    <= '0;
         tens    <= '0;
         hund    <= '0;
         thou    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opnd    <= bin;
                  scratch <= '0;
                  step    <= '0;
                  busy    <= 1'b1;
               end
            end
            CONV: begin
               {scratch, opnd} <= {adj, opnd} << 1;
               step            <= step + CNT_W'(1);
            end
            DONE: begin
               // Display digits change only here, so the scanner never sees a partial value.
`ifdef BIN2BCD_SAT_EN
               if (sat)
                  {thou, hund, tens, ones} <= 16'h9999;
               else
                  {thou, hund, tens, ones} <= scratch[15:0];
`else
               {thou, hund, tens, ones} <= scratch[15:0];
`endif
               ovf  <= sat;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed scenarios plus random operands against a decimal-arithmetic model.
module tb_bin2bcd_seq;

   localparam int BIN_W = 14;

   logic             CLK;
   logic             RST_N;
   logic             start;
   logic [BIN_W-1:0] bin;
   logic [3:0]       ones, tens, hund, thou;
   logic             busy, done, ovf;

   int errors = 0;
   int checks = 0;

   logic [15:0] prev_d;
   logic        prev_o;

   bin2bcd_seq #(.BIN_W(BIN_W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .start (start),
      .bin   (bin),
      .ones  (ones),
      .tens  (tens),
      .hund  (hund),
      .thou  (thou),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] model_digits(input int v);
      int m;
      m = v % 10000;
`ifdef BIN2BCD_SAT_EN
      if (v > 9999) m = 9999;
`endif
      return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {thou, hund, tens, ones};
   endfunction

   // Entered at a negedge; returns at the negedge after the result-load edge.
   // poke: edge index at which a stray start with bin=42 is sampled (0 = none).
   task automatic convert(input int v, input int poke, input bit noise);
      logic [15:0] exp_d;
      logic        exp_o;
      exp_d = model_digits(v);
      exp_o = (v > 9999);
      bin   = BIN_W'(v);
      start = 1'b1;
      for (int e = 0; e <= BIN_W; e++) begin
         @(negedge CLK);
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bin   = BIN_W'($urandom);
         if (e + 1 == poke) begin
            start = 1'b1;
            bin   = BIN_W'(42);
         end
         check("busy_conv", 16'(busy), 16'd1);
         check("done_conv", 16'(done), 16'd0);
         check("digits_hold", digits(), prev_d);
         check("ovf_hold", 16'(ovf), 16'(prev_o));
      end
      @(negedge CLK);
      start = 1'b0;
      check("done_pulse", 16'(done), 16'd1);
      check("busy_clear", 16'(busy), 16'd0);
      check("digits_result", digits(), exp_d);
      check("ovf_result", 16'(ovf), 16'(exp_o));
      prev_d = exp_d;
      prev_o = exp_o;
   endtask

   initial begin
      RST_N  = 1'b0;
      start  = 1'b1;
      bin    = BIN_W'(1234);
      prev_d = 16'h0000;
      prev_o = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_digits", digits(), 16'h0000);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      check("rst_ovf", 16'(ovf), 16'd0);
      RST_N = 1'b1;
      start = 1'b0;
      @(negedge CLK);
      check("idle_busy", 16'(busy), 16'd0);

      convert(1234, 0, 1'b0);
      @(negedge CLK);
      check("done_one_cycle", 16'(done), 16'd0);

      // back-to-back: second start sampled on the edge right after done rises
      convert(0, 0, 1'b0);
      convert(9999, 0, 1'b0);
      @(negedge CLK);
      check("done_b2b_low", 16'(done), 16'd0);

      convert(12345, 0, 1'b0);
      convert(5678, 0, 1'b0);
      convert(100, 5, 1'b0);
      repeat (3) begin
         @(negedge CLK);
         check("no_queued_start", 16'(busy), 16'd0);
         check("digits_idle", digits(), 16'h0100);
      end

      // abort a conversion with reset at E7, start asserted alongside reset
      bin   = BIN_W'(4321);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (6) @(negedge CLK);
      RST_N = 1'b0;
      start = 1'b1;
      @(negedge CLK);
      RST_N = 1'b1;
      start = 1'b0;
      check("abort_digits", digits(), 16'h0000);
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_done", 16'(done), 16'd0);
      check("abort_ovf", 16'(ovf), 16'd0);
      prev_d = 16'h0000;
      prev_o = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         check("abort_no_done", 16'(done), 16'd0);
         check("abort_idle", 16'(busy), 16'd0);
      end
      convert(4321, 0, 1'b0);

      convert(10000, 0, 1'b1);
      convert(16383, 0, 1'b1);
      convert(9, 0, 1'b1);
      repeat (25) convert(int'($urandom_range(0, (1 << BIN_W) - 1)), 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
